// File: rtl/nb_read_sequencer_if.sv
// Bundle between the count/back-pressure side and the neighbour-cell position read stream.
// The master modport is the upstream/downstream environment; the sequencer is the slave.
interface nb_read_sequencer_if #(
  parameter int unsigned NUM_NEIGHBOR_CELLS = 13,
  parameter int unsigned NUM_FILTER         = 7,
  parameter int unsigned PARTICLE_ID_WIDTH  = 7
);
  localparam int unsigned NUM_CELLS = NUM_NEIGHBOR_CELLS + 1;

  logic                                   start;
  logic                                   count_valid;
  logic [NUM_CELLS*PARTICLE_ID_WIDTH-1:0] cell_particle_count;
  logic [PARTICLE_ID_WIDTH-1:0]           ref_particle_count;
  logic [NUM_FILTER-1:0]                  filter_almost_full;
  logic                                   phase;
  logic                                   reading_particle_num;
  logic                                   pause_reading;
  logic [PARTICLE_ID_WIDTH-1:0]           ref_id;
  logic [PARTICLE_ID_WIDTH-1:0]           particle_id;
  logic [NUM_CELLS-1:0]                   broadcast_done;
  logic                                   busy;
  logic                                   done;

  modport master (
    output start, count_valid, cell_particle_count, ref_particle_count, filter_almost_full,
    input  phase, reading_particle_num, pause_reading, ref_id, particle_id,
           broadcast_done, busy, done
  );

  modport slave (
    input  start, count_valid, cell_particle_count, ref_particle_count, filter_almost_full,
    output phase, reading_particle_num, pause_reading, ref_id, particle_id,
           broadcast_done, busy, done
  );
endinterface

// File: rtl/nb_read_sequencer.sv
// Neighbour-cell position read sequencer: count read, then per-reference sweeps over both
// neighbour phases with per-cell exhaustion flags and filter back-pressure stalls.
module nb_read_sequencer #(
  parameter int unsigned NUM_NEIGHBOR_CELLS = 13,
  parameter int unsigned NUM_FILTER         = 7,
  parameter int unsigned PARTICLE_ID_WIDTH  = 7,
  parameter int unsigned DRAIN_CYCLES       = 4
) (
  input  logic               clk,
  input  logic               rst,
  nb_read_sequencer_if.slave bus
);
  localparam int unsigned W         = PARTICLE_ID_WIDTH;
  localparam int unsigned NUM_CELLS = NUM_NEIGHBOR_CELLS + 1;
  localparam int unsigned CW        = NUM_CELLS * W;
  localparam int unsigned DW        = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_READ_NUM, S_WAIT_CNT, S_MAX, S_SWEEP, S_DRAIN
  } state_e;

  state_e               state_q, state_d;
  logic                 phase_q, phase_d;
  logic                 rpn_q, rpn_d;
  logic                 pause_q, pause_d;
  logic [W-1:0]         ref_id_q, ref_id_d;
  logic [W-1:0]         pid_q, pid_d;
  logic [NUM_CELLS-1:0] bd_q, bd_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [W-1:0]         ref_cnt_q, ref_cnt_d;
  logic [W-1:0]         max0_q, max0_d;
  logic [W-1:0]         max1_q, max1_d;
  logic [DW-1:0]        drain_q, drain_d;

  logic [W-1:0]         max0_c, max1_c, cur_max_c;
  logic                 last_phase_c;

  // Per-phase maxima over the latched counts
  always_comb begin
    max0_c = '0;
    max1_c = '0;
    for (int unsigned c = 0; c < NUM_FILTER; c++) begin
      if (cnt_q[c*W +: W] > max0_c) max0_c = cnt_q[c*W +: W];
    end
    for (int unsigned c = NUM_FILTER; c < NUM_CELLS; c++) begin
      if (cnt_q[c*W +: W] > max1_c) max1_c = cnt_q[c*W +: W];
    end
  end

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    rpn_d     = 1'b0;
    pause_d   = 1'b0;
    ref_id_d  = ref_id_q;
    pid_d     = pid_q;
    cnt_d     = cnt_q;
    ref_cnt_d = ref_cnt_q;
    max0_d    = max0_q;
    max1_d    = max1_q;
    drain_d   = drain_q;
    bd_d      = '0;

    cur_max_c    = phase_q ? max1_q : max0_q;
    // Phase 1 is always last; phase 0 is last only when phase 1 is empty
    last_phase_c = phase_q || (max1_q == '0);

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d  = S_READ_NUM;
          rpn_d    = 1'b1;
          ref_id_d = '0;
          pid_d    = '0;
          phase_d  = 1'b0;
        end
      end
      S_READ_NUM: state_d = S_WAIT_CNT;
      S_WAIT_CNT: begin
        if (bus.count_valid) begin
          cnt_d     = bus.cell_particle_count;
          ref_cnt_d = bus.ref_particle_count;
          state_d   = S_MAX;
        end
      end
      S_MAX: begin
        max0_d = max0_c;
        max1_d = max1_c;
        if ((ref_cnt_q == '0) || ((max0_c == '0) && (max1_c == '0))) begin
          state_d = S_DRAIN;
          drain_d = '0;
        end else begin
          state_d  = S_SWEEP;
          ref_id_d = W'(1);
          pid_d    = W'(1);
          phase_d  = (max0_c == '0);
        end
      end
      S_SWEEP: begin
        if (|bus.filter_almost_full) begin
          pause_d = 1'b1;
        end else if (pid_q != cur_max_c) begin
          pid_d = pid_q + W'(1);
        end else if ((ref_id_q == ref_cnt_q) && last_phase_c) begin
          state_d  = S_DRAIN;
          drain_d  = '0;
          pid_d    = '0;
          ref_id_d = '0;
          phase_d  = 1'b0;
        end else begin
          pid_d = W'(1);
          if (!phase_q && (max1_q != '0)) begin
            phase_d = 1'b1;
          end else begin
            ref_id_d = ref_id_q + W'(1);
            phase_d  = (max0_q == '0);
          end
        end
      end
      S_DRAIN: begin
        if (drain_q == DW'(DRAIN_CYCLES - 1)) state_d = S_IDLE;
        else                                  drain_d = drain_q + DW'(1);
      end
      default: state_d = S_IDLE;
    endcase

    // Exhaustion flags follow the address being issued; frozen while stalled
    if (state_d == S_DRAIN) begin
      bd_d = '1;
    end else if (state_d == S_SWEEP) begin
      if (pause_d) begin
        bd_d = bd_q;
      end else begin
        for (int unsigned c = 0; c < NUM_CELLS; c++) bd_d[c] = (pid_d > cnt_q[c*W +: W]);
      end
    end

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DRAIN) && (drain_d == DW'(DRAIN_CYCLES - 1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      phase_q   <= 1'b0;
      rpn_q     <= 1'b0;
      pause_q   <= 1'b0;
      ref_id_q  <= '0;
      pid_q     <= '0;
      bd_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
      ref_cnt_q <= '0;
      max0_q    <= '0;
      max1_q    <= '0;
      drain_q   <= '0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      rpn_q     <= rpn_d;
      pause_q   <= pause_d;
      ref_id_q  <= ref_id_d;
      pid_q     <= pid_d;
      bd_q      <= bd_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cnt_q     <= cnt_d;
      ref_cnt_q <= ref_cnt_d;
      max0_q    <= max0_d;
      max1_q    <= max1_d;
      drain_q   <= drain_d;
    end
  end

  assign bus.phase                = phase_q;
  assign bus.reading_particle_num = rpn_q;
  assign bus.pause_reading        = pause_q;
  assign bus.ref_id               = ref_id_q;
  assign bus.particle_id          = pid_q;
  assign bus.broadcast_done       = bd_q;
  assign bus.busy                 = busy_q;
  assign bus.done                 = done_q;
endmodule

// File: tb/tb_nb_read_sequencer.sv
// Directed bench for nb_read_sequencer: table of count scenarios with hand-computed sweep
// lengths, an address-order model, and hand sequences for reset and start handling.
module tb_nb_read_sequencer;
  localparam int NNC   = 13;
  localparam int NF    = 7;
  localparam int PW    = 7;
  localparam int DRAIN = 4;
  localparam int NC    = NNC + 1;
  localparam int CW    = NC * PW;
  localparam logic [NF-1:0] FAF3 = NF'(8);

  typedef struct {
    int c0;          // count of cell 0
    int cph0;        // count of cells 1..NF-1
    int cph1;        // count of cells NF..NNC
    int refc;        // reference particles
    int exp_sweep;   // expected non-paused SWEEP cycles
    int pause_item;  // index of the address during which back-pressure is applied
    int pause_len;   // cycles filter_almost_full is held high
    int exp_pause;   // expected pause_reading cycles
  } vec_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  vec_t vecs[7];
  logic [31:0] exp_q[$];

  nb_read_sequencer_if #(.NUM_NEIGHBOR_CELLS(NNC), .NUM_FILTER(NF), .PARTICLE_ID_WIDTH(PW)) bus ();

  nb_read_sequencer #(
    .NUM_NEIGHBOR_CELLS(NNC), .NUM_FILTER(NF), .PARTICLE_ID_WIDTH(PW), .DRAIN_CYCLES(DRAIN)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int cell_cnt(input vec_t v, input int c);
    if (c == 0) return v.c0;
    if (c < NF) return v.cph0;
    return v.cph1;
  endfunction

  function automatic logic [CW-1:0] pack_counts(input vec_t v);
    logic [CW-1:0] r;
    r = '0;
    for (int c = 0; c < NC; c++) r[c*PW +: PW] = PW'(cell_cnt(v, c));
    return r;
  endfunction

  // Expected address stream: ref-major, phase 0 then phase 1, empty phases contribute nothing
  function automatic void build_exp(input vec_t v);
    int m0, m1, m;
    logic [NC-1:0] bd;
    exp_q.delete();
    m0 = (v.c0 > v.cph0) ? v.c0 : v.cph0;
    m1 = v.cph1;
    for (int r = 1; r <= v.refc; r++) begin
      for (int ph = 0; ph < 2; ph++) begin
        m = (ph == 0) ? m0 : m1;
        for (int p = 1; p <= m; p++) begin
          for (int c = 0; c < NC; c++) bd[c] = (p > cell_cnt(v, c));
          exp_q.push_back({3'b0, PW'(r), 1'(ph), PW'(p), bd});
        end
      end
    end
  endfunction

  task automatic start_and_load(input vec_t v);
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    check("read_num", 32'({bus.reading_particle_num, bus.busy, bus.ref_id, bus.particle_id}),
          32'({1'b1, 1'b1, PW'(0), PW'(0)}));
    @(negedge clk);
    check("wait_cnt", 32'({bus.reading_particle_num, bus.busy, bus.broadcast_done}),
          32'({1'b0, 1'b1, NC'(0)}));
    bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    check("start_ignored", 32'({bus.reading_particle_num, bus.busy}), 32'(2'b01));
    bus.cell_particle_count = pack_counts(v);
    bus.ref_particle_count  = PW'(v.refc);
    bus.count_valid         = 1'b1;
    @(negedge clk);
    bus.count_valid         = 1'b0;
    bus.cell_particle_count = '1;
    bus.ref_particle_count  = '0;
    check("max_state", 32'({bus.reading_particle_num, bus.pause_reading, bus.busy, bus.done,
                            bus.broadcast_done}), 32'({4'b0010, NC'(0)}));
    @(negedge clk);
  endtask

  task automatic sweep_and_drain(input vec_t v);
    int seen, paused, guard, faf_left;
    bit fired;
    logic [31:0] act;
    seen = 0; paused = 0; guard = 0; faf_left = 0; fired = 1'b0;
    build_exp(v);
    while (bus.broadcast_done != '1 && guard < 400) begin
      act = {3'b0, bus.ref_id, bus.phase, bus.particle_id, bus.broadcast_done};
      if (bus.pause_reading) begin
        paused++;
        if (seen > 0) check("pause_hold", act, exp_q[seen-1]);
      end else begin
        if (seen < exp_q.size()) check("sweep_addr", act, exp_q[seen]);
        else begin
          total++; bad++;
          $display("FAIL sweep_extra: got %0h expected no further address", act);
        end
        seen++;
      end
      if (!fired && v.pause_len != 0 && seen == v.pause_item + 1) begin
        fired = 1'b1;
        faf_left = v.pause_len;
      end
      bus.filter_almost_full = (faf_left > 0) ? FAF3 : '0;
      if (faf_left > 0) faf_left--;
      @(negedge clk);
      guard++;
    end
    bus.filter_almost_full = '0;
    check("sweep_len", 32'(seen), 32'(v.exp_sweep));
    check("pause_len", 32'(paused), 32'(v.exp_pause));
    for (int d = 0; d < DRAIN; d++) begin
      check("drain", 32'({bus.busy, bus.done, bus.pause_reading, bus.broadcast_done}),
            32'({1'b1, 1'(d == DRAIN - 1), 1'b0, {NC{1'b1}}}));
      @(negedge clk);
    end
    check("idle_after", 32'({bus.busy, bus.done, bus.reading_particle_num, bus.broadcast_done}), 32'(0));
  endtask

  initial begin
    int guard;
    total = 0;
    bad   = 0;
    //            c0  ph0 ph1 ref sweep pitem plen pexp
    vecs[0] = '{  3,  3,  3,  2,  12,   0,    0,   0};
    vecs[1] = '{  1,  4,  4,  1,   8,   0,    0,   0};
    vecs[2] = '{  2,  2,  0,  3,   6,   0,    0,   0};
    vecs[3] = '{  3,  3,  3,  0,   0,   0,    0,   0};
    vecs[4] = '{  3,  3,  3,  2,  12,   1,    5,   5};
    vecs[5] = '{  0,  0,  2,  2,   4,   0,    0,   0};
    vecs[6] = '{127,  0,  0,  1, 127,   0,    0,   0};

    rst = 1'b0;
    bus.start = 1'b0;
    bus.count_valid = 1'b0;
    bus.cell_particle_count = '0;
    bus.ref_particle_count = '0;
    bus.filter_almost_full = '0;
    repeat (2) @(negedge clk);
    check("reset_ctrl", 32'({bus.reading_particle_num, bus.pause_reading, bus.busy, bus.done, bus.phase}), 32'(0));
    check("reset_addr", 32'({bus.ref_id, bus.particle_id, bus.broadcast_done}), 32'(0));
    rst = 1'b1;
    @(negedge clk);
    check("idle_hold", 32'({bus.busy, bus.reading_particle_num}), 32'(0));

    for (int i = 0; i < 7; i++) begin
      start_and_load(vecs[i]);
      sweep_and_drain(vecs[i]);
    end

    // Asynchronous reset in the middle of a sweep, then a clean restart
    start_and_load(vecs[0]);
    guard = 0;
    while (!(bus.ref_id == PW'(2) && bus.particle_id == PW'(2)) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("reach_ref2_pid2", 32'({bus.ref_id, bus.particle_id}), 32'({PW'(2), PW'(2)}));
    #2 rst = 1'b0;
    #1;
    check("async_rst_ctrl", 32'({bus.reading_particle_num, bus.pause_reading, bus.busy, bus.done, bus.phase}), 32'(0));
    check("async_rst_addr", 32'({bus.ref_id, bus.particle_id, bus.broadcast_done}), 32'(0));
    @(negedge clk);
    check("rst_no_done", 32'({bus.busy, bus.done}), 32'(0));
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_idle", 32'({bus.busy, bus.done, bus.reading_particle_num}), 32'(0));
    start_and_load(vecs[0]);
    sweep_and_drain(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
